turn_signal_unit: RTL and testbench
===================================

TURN_SIGNAL_UNIT -- requirements
Module: turn_signal_unit

Interface
REQ-001 SHALL have parameter BLINK_HALF, default 20_000_000, meaning clock cycles per blink half-period (0.4 s at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE, default 500_000, meaning consecutive stable cycles needed to accept a button level (10 ms).
REQ-003 SHALL have port clk, input, 1 bit, meaning 50 MHz system clock.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port engine_on, input, 1 bit, meaning engine running.
REQ-006 SHALL have port btn_left, input, 1 bit, meaning raw asynchronous left-lever pushbutton, active-high.
REQ-007 SHALL have port btn_right, input, 1 bit, meaning raw right-lever pushbutton, active-high.
REQ-008 SHALL have port btn_hazard, input, 1 bit, meaning raw hazard pushbutton, active-high.
REQ-009 SHALL have port turn_signal_on, output, 1 bit, meaning blink phase to the sound unit click generator.
REQ-010 SHALL have port led_left, output, 1 bit, meaning left indicator lamp.
REQ-011 SHALL have port led_right, output, 1 bit, meaning right indicator lamp.
REQ-012 SHALL have port mode, output, 2 bits, meaning 00 OFF, 01 LEFT, 10 RIGHT, 11 HAZARD.

Function
REQ-013 Each button SHALL pass through a 2-FF synchronizer, then a debouncer.
REQ-014 Debouncer: counter clears while synced value equals accepted level; increments while it differs; at count DEBOUNCE-1 with value still differing, the level is accepted and the counter cleared.
REQ-015 A one-cycle press pulse SHALL fire on each accepted 0->1 transition; release SHALL fire nothing.
REQ-016 FSM states SHALL be OFF, LEFT, RIGHT, HAZARD, and mode SHALL equal the state encoding.
REQ-017 Hazard press SHALL move any non-HAZARD state to HAZARD and HAZARD to OFF, regardless of engine_on.
REQ-018 Left press with engine_on=1 SHALL move OFF->LEFT, LEFT->OFF, RIGHT->LEFT; right press SHALL behave symmetrically.
REQ-019 Left/right presses SHALL be ignored in HAZARD and when engine_on=0.
REQ-020 On a simultaneous hazard and left/right pulse, hazard SHALL win; simultaneous left+right without hazard SHALL be ignored.
REQ-021 engine_on=0 SHALL force LEFT/RIGHT to OFF on the next edge; HAZARD SHALL be unaffected.
REQ-022 Blink counter SHALL run only in non-OFF states, counting 0..BLINK_HALF-1, then wrap to 0 and toggle phase.
REQ-023 An OFF->active transition SHALL load counter=0 and phase=1, so lamps light on the same edge as the state change.
REQ-024 An active->active transition (e.g. LEFT->RIGHT, LEFT->HAZARD) SHALL keep counter and phase unchanged.
REQ-025 An active->OFF transition SHALL clear counter and phase on the same edge.
REQ-026 Outputs SHALL decode combinationally from registered state and phase: turn_signal_on=phase&(state!=OFF); led_left=phase&(LEFT|HAZARD); led_right=phase&(RIGHT|HAZARD).
REQ-027 Latency: the state SHALL update on the (DEBOUNCE+4)th rising edge after the first edge that samples a clean raw press.
REQ-028 A raw pulse or bounce shorter than DEBOUNCE synced cycles SHALL produce no press.

Reset
REQ-029 While rst=0, state SHALL be OFF, counter and phase 0, synchronizers and accepted levels 0, and all outputs 0.
REQ-030 Deassertion of rst SHALL take effect on the next clk edge; a button held through reset SHALL register as a press once debounced.
REQ-031 Reset asserted mid-blink SHALL clear all outputs immediately (asynchronously).

Verification (BLINK_HALF=10, DEBOUNCE=4)
REQ-032 engine_on=1, btn_left held 20 cycles -> mode=01 at edge 8; led_left=1 for 10 cycles, 0 for 10 cycles, repeating; led_right=0; turn_signal_on tracks led_left.
REQ-033 In LEFT at blink count 5, press right -> mode=10 with phase and count continuous; led_right takes over with no phase restart.
REQ-034 btn_left glitch of 3 cycles, or 1-cycle on/off bounce for 20 cycles then released -> mode stays 00, no press.
REQ-035 In LEFT, engine_on->0 -> mode=00 and all lamps 0 next edge; hazard press with engine_on=0 -> mode=11, both lamps blink together.
REQ-036 btn_hazard and btn_left pressed on the same cycle from OFF -> mode=11; a second hazard press -> mode=00 and outputs 0.
REQ-037 rst=0 pulsed mid-phase in HAZARD -> all outputs 0 without waiting for a clock edge; mode=00 after release.

Source files
------------

// File: rtl/turn_signal_unit.sv
// Turn-signal controller: debounced lever/hazard buttons drive a four-state
// mode machine and a blink generator that feeds the lamps and the click generator.
module turn_signal_unit #(
   parameter int BLINK_HALF = 20_000_000,
   parameter int DEBOUNCE   = 500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       engine_on,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_hazard,
   output logic       turn_signal_on,
   output logic       led_left,
   output logic       led_right,
   output logic [1:0] mode
);

   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE - 1);
   localparam logic [BW-1:0] BL_MAX = BW'(BLINK_HALF - 1);

   localparam int B_L = 0;
   localparam int B_R = 1;
   localparam int B_H = 2;

   typedef enum logic [1:0] {
      S_OFF    = 2'b00,
      S_LEFT   = 2'b01,
      S_RIGHT  = 2'b10,
      S_HAZARD = 2'b11
   } state_t;

   logic [2:0]    btn_raw;
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    level;
   logic [2:0]    level_d;
   logic [2:0]    press;
   logic [DW-1:0] db_cnt [3];

   state_t        state;
   state_t        state_nxt;
   logic [BW-1:0] blink_cnt;
   logic          phase;

   assign btn_raw = {btn_hazard, btn_right, btn_left};

   // Synchronize, debounce, then register a one-cycle pulse on each accepted rise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1   <= '0;
         sync2   <= '0;
         level   <= '0;
         level_d <= '0;
         press   <= '0;
         for (int i = 0; i < 3; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1   <= btn_raw;
         sync2   <= sync1;
         level_d <= level;
         press   <= level & ~level_d;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_MAX) begin
               level[i]  <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Hazard outranks everything; engine-off only releases the lever states.
   function automatic state_t next_state(input state_t cur, input logic eng,
                                         input logic [2:0] p);
      state_t nxt;
      nxt = cur;
      if (p[B_H]) begin
         nxt = (cur == S_HAZARD) ? S_OFF : S_HAZARD;
      end else if (cur == S_HAZARD) begin
         nxt = S_HAZARD;
      end else if (!eng) begin
         nxt = S_OFF;
      end else if (p[B_L] && !p[B_R]) begin
         nxt = (cur == S_LEFT) ? S_OFF : S_LEFT;
      end else if (p[B_R] && !p[B_L]) begin
         nxt = (cur == S_RIGHT) ? S_OFF : S_RIGHT;
      end
      return nxt;
   endfunction

   assign state_nxt = next_state(state, engine_on, press);

   // Entering from OFF restarts the blink lit; active-to-active keeps the rhythm.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_OFF;
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt == S_OFF) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
         end else if (state == S_OFF) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
         end else if (blink_cnt == BL_MAX) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   assign mode           = state;
   assign turn_signal_on = phase & (state != S_OFF);
   assign led_left       = phase & ((state == S_LEFT)  || (state == S_HAZARD));
   assign led_right      = phase & ((state == S_RIGHT) || (state == S_HAZARD));

endmodule

// File: tb/tb_turn_signal_unit.sv
// Bench for turn_signal_unit: per-cycle expected outputs from a window-based
// reference model are queued at each rising edge and checked on the falling edge.
module tb_turn_signal_unit;

   localparam int BH = 10;
   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       engine_on = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       btn_hazard = 1'b0;
   logic       turn_signal_on;
   logic       led_left;
   logic       led_right;
   logic [1:0] mode;

   turn_signal_unit #(.BLINK_HALF(BH), .DEBOUNCE(DB)) dut (
      .clk            (clk),
      .rst            (rst),
      .engine_on      (engine_on),
      .btn_left       (btn_left),
      .btn_right      (btn_right),
      .btn_hazard     (btn_hazard),
      .turn_signal_on (turn_signal_on),
      .led_left       (led_left),
      .led_right      (led_right),
      .mode           (mode)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard storage ----------------
   logic [4:0] exp_q[$];
   int         n_cmp = 0;
   int         n_err = 0;

   // ---------------- reference model ----------------
   // Mode: 0 OFF, 1 LEFT, 2 RIGHT, 3 HAZARD. A button level flips once the last
   // DB synchronized samples all disagree with it; the press acts two edges later.
   int m_state, m_cnt, m_phase;
   int m_level[3];
   int m_hist[3][$];
   bit m_pipe0[3];
   bit m_pipe1[3];

   function automatic logic [4:0] pack_out(input int st, input int ph);
      logic [1:0] s;
      logic       p;
      s = st[1:0];
      p = (ph != 0);
      return {s, p && (st == 1 || st == 3), p && (st == 2 || st == 3), p && (st != 0)};
   endfunction

   task automatic model_step(input logic r, input logic e, input logic [2:0] raw);
      bit fire[3];
      int prev, ns;
      if (!r) begin
         m_state = 0;
         m_cnt   = 0;
         m_phase = 0;
         for (int b = 0; b < 3; b++) begin
            m_level[b] = 0;
            m_hist[b].delete();
            repeat (DB + 2) m_hist[b].push_back(0);
            m_pipe0[b] = 1'b0;
            m_pipe1[b] = 1'b0;
         end
         return;
      end
      for (int b = 0; b < 3; b++) begin
         int n;
         bit all_diff;
         m_hist[b].push_back(int'(raw[b]));
         n = m_hist[b].size();
         all_diff = 1'b1;
         for (int k = 0; k < DB; k++)
            if (m_hist[b][n-3-k] == m_level[b]) all_diff = 1'b0;
         fire[b]    = m_pipe1[b];
         m_pipe1[b] = m_pipe0[b];
         m_pipe0[b] = 1'b0;
         if (all_diff) begin
            m_level[b] = 1 - m_level[b];
            m_pipe0[b] = (m_level[b] == 1);
         end
         if (n > 64) void'(m_hist[b].pop_front());
      end
      prev = m_state;
      ns   = prev;
      if (fire[2])                  ns = (prev == 3) ? 0 : 3;
      else if (prev == 3)           ns = 3;
      else if (!e)                  ns = 0;
      else if (fire[0] && !fire[1]) ns = (prev == 1) ? 0 : 1;
      else if (fire[1] && !fire[0]) ns = (prev == 2) ? 0 : 2;
      if (ns == 0) begin
         m_cnt = 0;
         m_phase = 0;
      end else if (prev == 0) begin
         m_cnt = 0;
         m_phase = 1;
      end else begin
         m_cnt = m_cnt + 1;
         if (m_cnt == BH) begin
            m_cnt = 0;
            m_phase = 1 - m_phase;
         end
      end
      m_state = ns;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step(rst, engine_on, {btn_hazard, btn_right, btn_left});
         exp_q.push_back(pack_out(m_state, m_phase));
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         logic [4:0] e;
         logic [4:0] a;
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {mode, led_left, led_right, turn_signal_on};
            n_cmp++;
            if (a !== e) begin
               n_err++;
               $display("FAIL outputs @%0t: got mode=%b led_l=%b led_r=%b ts=%b, expected mode=%b led_l=%b led_r=%b ts=%b",
                        $time, a[4:3], a[2], a[1], a[0], e[4:3], e[2], e[1], e[0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reset asserted between edges; outputs must drop without any clock edge.
   task automatic async_reset(input int hold);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({mode, led_left, led_right, turn_signal_on} !== 5'b0) begin
         n_err++;
         $display("FAIL async_reset: got mode=%b led_l=%b led_r=%b ts=%b, expected all 0",
                  mode, led_left, led_right, turn_signal_on);
      end
      cyc(hold);
      rst = 1'b1;
   endtask

   task automatic set_btns(input logic l, input logic r, input logic h);
      btn_left   = l;
      btn_right  = r;
      btn_hazard = h;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      cyc(3);
      rst = 1'b1;
      engine_on = 1'b1;
      cyc(2);

      // left held 20 cycles, then right press mid-blink
      set_btns(1, 0, 0); cyc(20); set_btns(0, 0, 0); cyc(3);
      set_btns(0, 1, 0); cyc(6); set_btns(0, 0, 0); cyc(15);

      // short glitch and bouncing lever must not register
      set_btns(1, 0, 0); cyc(3); set_btns(0, 0, 0); cyc(8);
      for (int i = 0; i < 20; i++) begin
         btn_left = ~btn_left;
         cyc(1);
      end
      set_btns(0, 0, 0); cyc(8);

      // engine off drops lever mode, hazard still works
      engine_on = 1'b0; cyc(4);
      set_btns(0, 0, 1); cyc(6); set_btns(0, 0, 0); cyc(25);
      set_btns(0, 0, 1); cyc(6); set_btns(0, 0, 0); cyc(4);
      engine_on = 1'b1; cyc(2);

      // simultaneous hazard + left from OFF, then reset while lamps lit
      set_btns(1, 0, 1); cyc(6); set_btns(0, 0, 0); cyc(4);
      async_reset(3);
      cyc(6);

      // second hazard press turns hazard off
      set_btns(0, 0, 1); cyc(6); set_btns(0, 0, 0); cyc(12);
      set_btns(0, 0, 1); cyc(6); set_btns(0, 0, 0); cyc(8);

      // button held through reset registers after release of reset
      set_btns(0, 0, 1);
      async_reset(3);
      cyc(8); set_btns(0, 0, 0); cyc(15);

      // randomized traffic
      repeat (260) begin
         int act, hold, gap;
         act  = $urandom_range(0, 10);
         hold = $urandom_range(1, 9);
         gap  = $urandom_range(0, 14);
         case (act)
            0, 1: set_btns(1, 0, 0);
            2, 3: set_btns(0, 1, 0);
            4:    set_btns(0, 0, 1);
            5:    set_btns(1, 0, 1);
            6:    set_btns(1, 1, 0);
            7:    engine_on = ($urandom_range(0, 3) != 0);
            8: begin
               for (int i = 0; i < 2 * hold; i++) begin
                  set_btns(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                  cyc(1);
               end
            end
            9:       if ($urandom_range(0, 3) == 0) async_reset(2);
            default: engine_on = 1'b1;
         endcase
         cyc(hold);
         set_btns(0, 0, 0);
         cyc(gap);
      end

      cyc(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
